mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch stage and the load/store unit of the pipelined core.
- Registers each granted transaction and holds it stable on the memory port until the memory acknowledges with mem_ready.
- Returns read data to the owner of the transaction and stalls fetch while it waits.
- Load/store has priority; a bounded-run counter prevents fetch starvation. A flush input discards in-flight fetch responses after redirects (jal/jalr/branch).

Parameters:
MAX_LS_RUN, 4, max consecutive load/store grants while if_req is pending before fetch is forced to win (range 1..15)

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
if_req  input  1  fetch request, level; held until if_valid
if_addr  input  32  fetch address, stable while if_req high
flush  input  1  redirect pulse; discard pending/granted fetch response
if_rdata  output  32  fetched instruction
if_valid  output  1  one-cycle pulse, if_rdata valid
if_stall  output  1  fetch must hold pc
ls_req  input  1  load/store request, level; held until ls_valid
ls_we  input  1  1 = write
ls_be  input  4  byte enables
ls_addr  input  32  data address
ls_wdata  input  32  write data
ls_rdata  output  32  load data
ls_valid  output  1  one-cycle pulse, read data valid / write done
mem_req  output  1  memory request
mem_we  output  1  memory write enable
mem_be  output  4  memory byte enables
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid with mem_ready
mem_ready  input  1  memory completes current request this cycle

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - state=IDLE; mem_req, mem_we, if_valid, ls_valid = 0.
  - mem_be, mem_addr, mem_wdata, if_rdata, ls_rdata = 0.
  - ls_run=0; flush_pend=0.
- Reset mid-transaction abandons it; no valid pulse is produced.
- FSM states:
  - IDLE:
    - Arbitrate among requests sampled this cycle.
    - Fetch wins if (if_req & ~flush) and (~ls_req or ls_run==MAX_LS_RUN); otherwise load/store wins if ls_req.
    - The winner's address and controls are registered into mem_* (fetch: mem_we=0, mem_be=4'hF, mem_wdata=0). mem_req=1 from the next cycle.
    - Next state is BUSY_IF or BUSY_LS. With no requests, stay in IDLE with mem_req=0.
  - BUSY_IF / BUSY_LS:
    - mem_* held constant while mem_ready=0; no timeout.
    - On mem_ready=1: mem_req drops next cycle, state returns to IDLE, and the response register is loaded.
- Response timing: the valid pulse is asserted in the cycle after mem_ready.
  - Fetch: if_rdata=mem_rdata and if_valid=1, unless flush_pend.
  - Load/store: ls_valid=1; ls_rdata=mem_rdata only when ~mem_we (writes leave ls_rdata unchanged).
  - The valid pulse and the IDLE arbitration cycle coincide.
  - A requester wanting back-to-back access keeps req high and presents the next address in its valid cycle; otherwise it must drop req in that cycle.
- Minimum latency: request seen in IDLE at cycle N, mem_req at N+1, mem_ready at N+1, valid at N+2. Throughput is one access per 2 cycles.
- Flush:
  - In BUSY_IF, flush sets flush_pend. The memory access still completes, but if_valid is suppressed, and flush_pend clears on that completion.
  - Flush in IDLE blocks a fetch grant that cycle.
  - Flush has no effect on load/store transactions.
- if_stall = if_req & ~if_valid (combinational). It is also 1 whenever flush_pend=1.
- Starvation counter ls_run (4 bits):
  - +1 on each load/store grant made while if_req=1.
  - Cleared on a fetch grant or whenever if_req=0 in IDLE.
  - Saturates at MAX_LS_RUN.
- Simultaneous events:
  - mem_ready in the same cycle as flush in BUSY_IF suppresses the response.
  - rst overrides everything.
  - mem_ready while in IDLE is ignored.

Test Plan:
- Fetch only:
  - Stimulus: if_req=1, if_addr=0x100, mem_ready returned one cycle after mem_req, mem_rdata=0x00000013.
  - Required: mem_req at N+1 with mem_addr=0x100, mem_we=0, mem_be=F; if_valid at N+3 with if_rdata=0x13; if_stall high until then.
- Collision:
  - Stimulus: if_req and ls_req (write, addr 0x2000, be=0x3, wdata 0xDEADBEEF) both high at N.
  - Required: load/store granted first with mem_we=1, mem_be=3; ls_valid pulses; ls_rdata unchanged; fetch granted in the following IDLE.
- Starvation, MAX_LS_RUN=4:
  - Stimulus: ls_req held high with continuous loads, if_req high.
  - Required: exactly 4 load/store grants, then a fetch grant, then load/store again; ls_run returns to 0 after the fetch grant.
- Flush:
  - Stimulus: flush pulse in BUSY_IF; mem_ready 3 cycles later.
  - Required: no if_valid pulse; if_stall high until the next fetch completes; a new fetch from the updated if_addr is issued in the next IDLE.
- Wait states and reset:
  - Stimulus: mem_ready held low for 5 cycles.
  - Required: mem_addr, mem_wdata, mem_be stable throughout.
  - Stimulus: assert rst mid-wait.
  - Required: mem_req=0 immediately, no valid pulse; after release, IDLE with all outputs 0.
- Back-to-back load:
  - Stimulus: ls_addr changes to 0x2004 in the ls_valid cycle with ls_req held high.
  - Required: a second mem_req with mem_addr=0x2004 in the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the
// load/store unit. Load/store normally wins; a run counter lets fetch through
// after MAX_LS_RUN back-to-back load/store grants while fetch is waiting.
// Each granted access is registered and held on the port until mem_ready,
// and the response is returned one cycle later as a single valid pulse.
module mem_port_arbiter #(
    parameter int MAX_LS_RUN = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_flush,
    output logic [31:0] o_if_rdata,
    output logic        o_if_valid,
    output logic        o_if_stall,
    input  logic        i_ls_req,
    input  logic        i_ls_we,
    input  logic [3:0]  i_ls_be,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    output logic [31:0] o_ls_rdata,
    output logic        o_ls_valid,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY_IF,
        ST_BUSY_LS
    } state_t;

    localparam logic [3:0] LP_MAX_RUN = 4'(MAX_LS_RUN);

    state_t      r_state;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_if_rdata;
    logic        r_if_valid;
    logic [31:0] r_ls_rdata;
    logic        r_ls_valid;
    logic [3:0]  r_ls_run;
    logic        r_flush_pend;

    logic        w_ls_run_max;
    logic        w_if_win;
    logic        w_ls_win;
    logic        w_if_suppress;

    assign w_ls_run_max  = (r_ls_run == LP_MAX_RUN);
    // A flush in the arbitration cycle refers to the fetch being requested, so it cannot win.
    assign w_if_win      = i_if_req & ~i_flush & (~i_ls_req | w_ls_run_max);
    assign w_ls_win      = i_ls_req & ~w_if_win;
    // A redirect seen earlier or in the completion cycle itself kills the fetch response.
    assign w_if_suppress = r_flush_pend | i_flush;

    // Arbitration, transaction hold and response capture as one registered FSM.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 4'h0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_if_rdata   <= 32'h0;
            r_if_valid   <= 1'b0;
            r_ls_rdata   <= 32'h0;
            r_ls_valid   <= 1'b0;
            r_ls_run     <= 4'h0;
            r_flush_pend <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_ls_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_if_win) begin
                        r_state     <= ST_BUSY_IF;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= 4'hF;
                        r_mem_addr  <= i_if_addr;
                        r_mem_wdata <= 32'h0;
                        r_ls_run    <= 4'h0;
                    end else if (w_ls_win) begin
                        r_state     <= ST_BUSY_LS;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= i_ls_we;
                        r_mem_be    <= i_ls_be;
                        r_mem_addr  <= i_ls_addr;
                        r_mem_wdata <= i_ls_wdata;
                        if (!i_if_req) begin
                            r_ls_run <= 4'h0;
                        end else if (!w_ls_run_max) begin
                            r_ls_run <= r_ls_run + 4'd1;
                        end
                    end else if (!i_if_req) begin
                        r_ls_run <= 4'h0;
                    end
                end
                ST_BUSY_IF: begin
                    if (i_mem_ready) begin
                        r_state      <= ST_IDLE;
                        r_mem_req    <= 1'b0;
                        r_flush_pend <= 1'b0;
                        if (!w_if_suppress) begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= i_mem_rdata;
                        end
                    end else if (i_flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                ST_BUSY_LS: begin
                    if (i_mem_ready) begin
                        r_state    <= ST_IDLE;
                        r_mem_req  <= 1'b0;
                        r_ls_valid <= 1'b1;
                        if (!r_mem_we) begin
                            r_ls_rdata <= i_mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Fetch holds its pc until its data arrives, and throughout a discarded access.
    assign o_if_stall  = (i_if_req & ~r_if_valid) | r_flush_pend;

    assign o_if_rdata  = r_if_rdata;
    assign o_if_valid  = r_if_valid;
    assign o_ls_rdata  = r_ls_rdata;
    assign o_ls_valid  = r_ls_valid;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_be    = r_mem_be;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a wait-state
// memory responder, a response scoreboard and a log of granted addresses.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        isFetch;
        logic        isWrite;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        flush;
    logic [31:0] ifRdata;
    logic        ifValid;
    logic        ifStall;
    logic        lsReq;
    logic        lsWe;
    logic [3:0]  lsBe;
    logic [31:0] lsAddr;
    logic [31:0] lsWdata;
    logic [31:0] lsRdata;
    logic        lsValid;
    logic        memReq;
    logic        memWe;
    logic [3:0]  memBe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memReady;

    int          compareCount = 0;
    int          failCount    = 0;
    int          memWait      = 0;
    int          memCnt       = 0;
    exp_t        sbQueue[$];
    logic [31:0] grantLog[$];
    logic        prevMemReq   = 1'b0;
    logic [31:0] lastLoad     = 32'h0;

    mem_port_arbiter #(.MAX_LS_RUN(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_if_req    (ifReq),
        .i_if_addr   (ifAddr),
        .i_flush     (flush),
        .o_if_rdata  (ifRdata),
        .o_if_valid  (ifValid),
        .o_if_stall  (ifStall),
        .i_ls_req    (lsReq),
        .i_ls_we     (lsWe),
        .i_ls_be     (lsBe),
        .i_ls_addr   (lsAddr),
        .i_ls_wdata  (lsWdata),
        .o_ls_rdata  (lsRdata),
        .o_ls_valid  (lsValid),
        .o_mem_req   (memReq),
        .o_mem_we    (memWe),
        .o_mem_be    (memBe),
        .o_mem_addr  (memAddr),
        .o_mem_wdata (memWdata),
        .i_mem_rdata (memRdata),
        .i_mem_ready (memReady)
    );

    // Free-running core clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait outside the bounded helpers ever hangs.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Fixed read-only memory contents used to predict read data.
    function automatic logic [31:0] memModel(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign memRdata = memReady ? memModel(memAddr) : 32'h0BAD_0BAD;

    // Memory responder: raises mem_ready after memWait cycles of mem_req.
    always @(negedge clk) begin
        if (rst || !memReq) begin
            memReady = 1'b0;
            memCnt   = 0;
        end else if (memCnt >= memWait) begin
            memReady = 1'b1;
        end else begin
            memCnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic lReq,
                                 input logic lWe, input logic [3:0] lBe,
                                 input logic [31:0] lAddr, input logic [31:0] lWdata);
        ifReq   = iReq;
        ifAddr  = iAddr;
        lsReq   = lReq;
        lsWe    = lWe;
        lsBe    = lBe;
        lsAddr  = lAddr;
        lsWdata = lWdata;
    endtask

    function automatic logic sigVal(input int which);
        case (which)
            0:       return memReq;
            1:       return ifValid;
            2:       return lsValid;
            default: return ifValid | lsValid;
        endcase
    endfunction

    task automatic waitSignal(input int which, input int maxCycles, input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!sigVal(which) && cycles < maxCycles);
        checkOutput(tag, 32'(sigVal(which)), 32'h1);
    endtask

    task automatic checkIdleOutputs(input string pfx);
        checkOutput({pfx, "MemReq"},   32'(memReq),   32'h0);
        checkOutput({pfx, "MemWe"},    32'(memWe),    32'h0);
        checkOutput({pfx, "MemBe"},    32'(memBe),    32'h0);
        checkOutput({pfx, "MemAddr"},  memAddr,       32'h0);
        checkOutput({pfx, "MemWdata"}, memWdata,      32'h0);
        checkOutput({pfx, "IfRdata"},  ifRdata,       32'h0);
        checkOutput({pfx, "LsRdata"},  lsRdata,       32'h0);
        checkOutput({pfx, "IfValid"},  32'(ifValid),  32'h0);
        checkOutput({pfx, "LsValid"},  32'(lsValid),  32'h0);
        checkOutput({pfx, "IfStall"},  32'(ifStall),  32'h0);
    endtask

    // Scoreboard: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            lastLoad = 32'h0;
        end else if (ifValid || lsValid) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpectedValid", {30'b0, ifValid, lsValid}, 32'h0);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("validKind", {30'b0, ifValid, lsValid}, e.isFetch ? 32'h2 : 32'h1);
                if (e.isFetch) begin
                    checkOutput("ifRdata", ifRdata, e.data);
                end else if (e.isWrite) begin
                    checkOutput("lsRdataHeld", lsRdata, lastLoad);
                end else begin
                    checkOutput("lsRdata", lsRdata, e.data);
                    lastLoad = e.data;
                end
            end
        end
    end

    // Grant log: each rising edge of mem_req is one new granted access.
    always @(negedge clk) begin
        if (rst) begin
            prevMemReq = 1'b0;
        end else begin
            if (memReq && !prevMemReq) grantLog.push_back(memAddr);
            prevMemReq = memReq;
        end
    end

    initial begin
        int cyc;
        int stallLow;
        rst   = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] fetch only");
        memWait = 1;
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        sbQueue.push_back('{1'b1, 1'b0, 32'h0000_0013});
        #1 checkOutput("fetchStallReq", 32'(ifStall), 32'h1);
        waitSignal(0, 10, "fetchMemReq", cyc);
        checkOutput("fetchReqLatency", 32'(cyc), 32'd1);
        checkOutput("fetchMemAddr", memAddr, 32'h100);
        checkOutput("fetchMemWe", 32'(memWe), 32'h0);
        checkOutput("fetchMemBe", 32'(memBe), 32'hF);
        checkOutput("fetchMemWdata", memWdata, 32'h0);
        checkOutput("fetchStallWait", 32'(ifStall), 32'h1);
        waitSignal(1, 10, "fetchValid", cyc);
        checkOutput("fetchValidLatency", 32'(cyc), 32'd2);
        checkOutput("fetchStallInValid", 32'(ifStall), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        $display("[TB] collision");
        @(negedge clk);
        memWait = 0;
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b1, 4'h3, 32'h2000, 32'hDEAD_BEEF);
        sbQueue.push_back('{1'b0, 1'b1, 32'h0});
        sbQueue.push_back('{1'b1, 1'b0, memModel(32'h300)});
        waitSignal(0, 10, "colMemReq", cyc);
        checkOutput("colMemWe", 32'(memWe), 32'h1);
        checkOutput("colMemBe", 32'(memBe), 32'h3);
        checkOutput("colMemAddr", memAddr, 32'h2000);
        checkOutput("colMemWdata", memWdata, 32'hDEAD_BEEF);
        waitSignal(2, 10, "colLsValid", cyc);
        lsReq = 1'b0;
        waitSignal(0, 10, "colFetchReq", cyc);
        checkOutput("colFetchAddr", memAddr, 32'h300);
        checkOutput("colFetchBe", 32'(memBe), 32'hF);
        waitSignal(1, 10, "colIfValid", cyc);
        ifReq = 1'b0;

        $display("[TB] starvation");
        @(negedge clk);
        grantLog.delete();
        applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 4'hF, 32'h3000, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) sbQueue.push_back('{1'b1, 1'b0, memModel(32'h400)});
            else                  sbQueue.push_back('{1'b0, 1'b0, memModel(32'h3000)});
        end
        for (int i = 0; i < 10; i++) waitSignal(3, 10, "starveValid", cyc);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("starveGrantCount", 32'(grantLog.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("starveGrant%0d", i), grantLog[i],
                        (i == 4 || i == 9) ? 32'h400 : 32'h3000);
        end

        $display("[TB] flush during fetch wait");
        @(negedge clk);
        memWait = 4;
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        waitSignal(0, 10, "flushMemReq", cyc);
        flush = 1'b1;
        @(negedge clk);
        flush  = 1'b0;
        ifAddr = 32'h600;
        sbQueue.push_back('{1'b1, 1'b0, memModel(32'h600)});
        stallLow = 0;
        cyc      = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!ifStall) stallLow++;
        end while (memReq && cyc < 20);
        waitSignal(0, 10, "flushRefetchReq", cyc);
        checkOutput("flushRefetchAddr", memAddr, 32'h600);
        checkOutput("flushStallRefetch", 32'(ifStall), 32'h1);
        waitSignal(1, 20, "flushRefetchValid", cyc);
        checkOutput("flushStallHeld", 32'(stallLow), 32'd0);
        ifReq = 1'b0;

        $display("[TB] flush with mem_ready");
        @(negedge clk);
        memWait = 0;
        applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        waitSignal(0, 10, "flushRdyMemReq", cyc);
        flush = 1'b1;
        @(negedge clk);
        flush  = 1'b0;
        ifAddr = 32'h704;
        sbQueue.push_back('{1'b1, 1'b0, memModel(32'h704)});
        waitSignal(0, 10, "flushRdyRefetch", cyc);
        checkOutput("flushRdyRefetchAddr", memAddr, 32'h704);
        waitSignal(1, 10, "flushRdyValid", cyc);
        ifReq = 1'b0;

        $display("[TB] flush in idle");
        @(negedge clk);
        applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        flush = 1'b1;
        sbQueue.push_back('{1'b1, 1'b0, memModel(32'h800)});
        @(negedge clk);
        checkOutput("flushIdleBlock", 32'(memReq), 32'h0);
        flush = 1'b0;
        waitSignal(0, 5, "flushIdleGrant", cyc);
        checkOutput("flushIdleLatency", 32'(cyc), 32'd1);
        checkOutput("flushIdleAddr", memAddr, 32'h800);
        waitSignal(1, 10, "flushIdleValid", cyc);
        ifReq = 1'b0;

        $display("[TB] wait states");
        @(negedge clk);
        memWait = 5;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'hC, 32'h2100, 32'hCAFE_F00D);
        sbQueue.push_back('{1'b0, 1'b1, 32'h0});
        waitSignal(0, 10, "waitMemReq", cyc);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("waitReq%0d", k), 32'(memReq), 32'h1);
            checkOutput($sformatf("waitAddr%0d", k), memAddr, 32'h2100);
            checkOutput($sformatf("waitWdata%0d", k), memWdata, 32'hCAFE_F00D);
            checkOutput($sformatf("waitBe%0d", k), 32'(memBe), 32'hC);
            @(negedge clk);
        end
        waitSignal(2, 10, "waitLsValid", cyc);
        lsReq = 1'b0;

        $display("[TB] reset mid-wait");
        @(negedge clk);
        memWait = 20;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h2200, 32'h0);
        waitSignal(0, 10, "rstMemReq", cyc);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("rstMemReqImmediate", 32'(memReq), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkIdleOutputs("postRst");

        $display("[TB] back-to-back load");
        memWait = 0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
        sbQueue.push_back('{1'b0, 1'b0, memModel(32'h2000)});
        sbQueue.push_back('{1'b0, 1'b0, memModel(32'h2004)});
        waitSignal(2, 10, "b2bFirstValid", cyc);
        lsAddr = 32'h2004;
        @(negedge clk);
        checkOutput("b2bSecondReq", 32'(memReq), 32'h1);
        checkOutput("b2bSecondAddr", memAddr, 32'h2004);
        waitSignal(2, 10, "b2bSecondValid", cyc);
        lsReq = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("sbDrained", 32'(sbQueue.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
